// File: rtl/mult_pkg.sv
// mult_pkg: shared operand width and FSM state encoding for mult_rom_seq.
package mult_pkg;
    localparam int N = 5;
    typedef enum logic [1:0] {OCIOSO = 2'd0, CALCULA = 2'd1, FIM = 2'd2} state_t;
endpackage

// File: rtl/rom.sv
// rom: N x N product table addressed {x,y}, combinational 2N-bit output.
module rom #(
    parameter int N = 5
) (
    input  logic [2*N-1:0] addr,
    output logic [2*N-1:0] data
);
    assign data = {{N{1'b0}}, addr[2*N-1:N]} * {{N{1'b0}}, addr[N-1:0]};
endmodule

// File: rtl/mult_rom_seq.sv
// mult_rom_seq: sequential 2N x 2N multiplier built from four N x N ROM lookups.
// Define MULT_ROM_SEQ_ZERO_SKIP_EN to finish zero-operand starts in one cycle.
module mult_rom_seq
    import mult_pkg::*;
#(
    parameter int N = mult_pkg::N
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           iniciar,
    input  logic [2*N-1:0] a,
    input  logic [2*N-1:0] b,
    output logic           ocupado,
    output logic           pronto,
    output logic [4*N-1:0] produto
);
    state_t         state, next;
    logic [1:0]     k;
    logic [2*N-1:0] ra, rb, rom_data;
    logic [4*N-1:0] acc, pp, sum;
    logic           start, skip;

    // k[1] picks the high half of a, k[0] the high half of b
    rom #(.N(N)) u_rom (
        .addr({k[1] ? ra[2*N-1:N] : ra[N-1:0], k[0] ? rb[2*N-1:N] : rb[N-1:0]}),
        .data(rom_data)
    );

`ifdef MULT_ROM_SEQ_ZERO_SKIP_EN
    assign skip = (a == '0) || (b == '0);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        start   = (state == OCIOSO) && iniciar;
        pp      = k == 2'd3 ? {rom_data, {(2*N){1'b0}}} :
                  k == 2'd0 ? {{(2*N){1'b0}}, rom_data} :
                              {{N{1'b0}}, rom_data, {N{1'b0}}};
        sum     = acc + pp;
        next    = state == OCIOSO  ? (iniciar ? (skip ? FIM : CALCULA) : OCIOSO) :
                  state == CALCULA ? (k == 2'd3 ? FIM : CALCULA) : OCIOSO;
        ocupado = state != OCIOSO;
        pronto  = state == FIM;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= OCIOSO;
            k       <= '0;
            acc     <= '0;
            ra      <= '0;
            rb      <= '0;
            produto <= '0;
        end else begin
            state <= next;
            if (start) begin
                ra  <= a;
                rb  <= b;
                acc <= '0;
                k   <= '0;
                if (skip) produto <= '0;
            end else if (state == CALCULA) begin
                acc <= sum;
                k   <= k + 2'd1;
                if (k == 2'd3) produto <= sum;
            end
        end
    end
endmodule

// File: tb/tb_mult_rom_seq.sv
// tb_mult_rom_seq: directed vectors checked against a cycle-count product model every cycle.
module tb_mult_rom_seq;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        iniciar = 1'b0;
    logic [9:0]  a = '0, b = '0;
    logic        ocupado, pronto;
    logic [19:0] produto;
    int          tests = 0, fails = 0;

`ifdef MULT_ROM_SEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    mult_rom_seq dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .a(a), .b(b),
        .ocupado(ocupado), .pronto(pronto), .produto(produto)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: cycles left busy (0 = idle, 1 = result cycle) and the product a*b
    int          cl = 0;
    logic [19:0] m_prod = '0, pend = '0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cl = 0;
            m_prod = '0;
        end else if (cl == 0) begin
            if (iniciar) begin
                pend = {10'b0, a} * {10'b0, b};
                cl = (SKIP && (a == 0 || b == 0)) ? 1 : 5;
                if (cl == 1) m_prod = pend;
            end
        end else begin
            cl--;
            if (cl == 1) m_prod = pend;
        end
    end

    always @(negedge clock) begin
        chk("ocupado", ocupado, cl != 0);
        chk("pronto", pronto, cl == 1);
        chk("produto", produto, m_prod);
    end

    task automatic wait_pronto(output int n, output int occ);
        n = 0;
        occ = 0;
        do begin
            @(negedge clock);
            n++;
            occ += int'(ocupado);
        end while (!pronto && n < 20);
    endtask

    task automatic run(input logic [9:0] x, input logic [9:0] y, input logic [19:0] e, input int lat);
        int n, occ;
        @(negedge clock);
        a = x;
        b = y;
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        wait_pronto(n, occ);
        chk("latency", n, lat);
        chk("ocupado_cycles", occ, lat);
        chk("result", produto, e);
    endtask

    initial begin
        int n, occ, cnt;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_ocupado", ocupado, 0);
        chk("reset_pronto", pronto, 0);
        chk("reset_produto", produto, 0);
        #2 reset_n = 1'b1;
        run(10'd5, 10'd10, 20'd50, 5);
        run(10'd1023, 10'd1023, 20'd1046529, 5);
        run(10'd992, 10'd33, 20'd32736, 5);
        run(10'd0, 10'd17, 20'd0, SKIP ? 1 : 5);
        run(10'd17, 10'd0, 20'd0, SKIP ? 1 : 5);
        // operands and iniciar wiggled during CALCULA
        @(negedge clock);
        a = 10'd7; b = 10'd9; iniciar = 1'b1;
        @(posedge clock);
        #1 a = 10'd1; b = 10'd2;
        @(posedge clock);
        #1 iniciar = 1'b0; a = 10'd500; b = 10'd600;
        wait_pronto(n, occ);
        chk("ignore_latency", n, 4);
        chk("ignore_result", produto, 63);
        @(negedge clock);
        chk("ignore_idle", ocupado, 0);
        // back-to-back with iniciar held high
        a = 10'd5; b = 10'd10; iniciar = 1'b1;
        wait_pronto(n, occ);
        chk("b2b_first", produto, 50);
        a = 10'd6; b = 10'd7;
        @(negedge clock);
        chk("b2b_gap", ocupado, 0);
        wait_pronto(n, occ);
        chk("b2b_second", produto, 42);
        chk("b2b_latency", n, 5);
        iniciar = 1'b0;
        // reset in the 2nd CALCULA cycle
        @(negedge clock);
        a = 10'd100; b = 10'd100; iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_ocupado", ocupado, 0);
        chk("abort_pronto", pronto, 0);
        chk("abort_produto", produto, 0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clock);
            cnt += int'(pronto) + int'(ocupado);
        end
        chk("abort_quiet", cnt, 0);
        run(10'd3, 10'd8, 20'd24, 5);
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
